// File: rtl/shiftadd_parallel_top.sv
// shiftadd_parallel_top: computes x mod m by repeated shift-add folding.
// Each fold replaces the bits of acc at and above bit bl with hi * c,
// where c = 2^bl - m. The product is built as a balanced adder tree of
// shifted copies of hi, one leaf per bit position of c. When acc drops
// below 2^bl, one conditional subtraction of m completes the reduction.
//
// Build option: define SHIFTADD_KYBER_CONST_EN to hardwire m = 3329,
// bl = 12 and c = 767. In that build m_i and m_bl_i are ignored and the
// tree taps are fixed.

package params_pkg;
    parameter int DATA_LENGTH    = 64;
    parameter int MODULUS        = 3329;
    parameter int MODULUS_LENGTH = 12;
endpackage

module shiftadd_parallel_top #(
    parameter int DATA_LENGTH = params_pkg::DATA_LENGTH
) (
    input  logic                   CLK_pci_sys_clk_p,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [DATA_LENGTH-1:0] x_i,
    input  logic [DATA_LENGTH-1:0] m_i,
    input  logic [DATA_LENGTH-1:0] m_bl_i,
    output logic [DATA_LENGTH-1:0] result_o,
    output logic                   valid_o
);

    // Width of the bit-length field and of the fold counter.
    localparam int BLW  = $clog2(DATA_LENGTH);
    localparam int CNTW = $clog2(DATA_LENGTH + 1);
    // Adder tree is built over a power-of-two number of leaves.
    localparam int LVL  = $clog2(DATA_LENGTH);
    localparam int NP   = 1 << LVL;

    localparam logic [DATA_LENGTH-1:0] ONE     = {{(DATA_LENGTH-1){1'b0}}, 1'b1};
    localparam logic [BLW-1:0]         DEF_BL  = BLW'(params_pkg::MODULUS_LENGTH);
    localparam logic [DATA_LENGTH-1:0] DEF_M   = DATA_LENGTH'(params_pkg::MODULUS);
    localparam logic [CNTW-1:0]        CNT_MAX = CNTW'(DATA_LENGTH);

    typedef enum logic {
        IDLE = 1'b0,
        FOLD = 1'b1
    } state_t;

    // Mask selecting bits [bl-1:0].
    function automatic logic [DATA_LENGTH-1:0] low_mask(input logic [BLW-1:0] bl);
        return ~({DATA_LENGTH{1'b1}} << bl);
    endfunction

    // Fold constant c = 2^bl - m, restricted to the taps below bl so that
    // an illegal m cannot enable taps that shift hi past the split point.
    function automatic logic [DATA_LENGTH-1:0] tap_mask(input logic [BLW-1:0]         bl,
                                                        input logic [DATA_LENGTH-1:0] m);
        return ((ONE << bl) - m) & low_mask(bl);
    endfunction

    // Final reduction step: one subtraction suffices because 2^bl < 2m.
    function automatic logic [DATA_LENGTH-1:0] cond_sub(input logic [DATA_LENGTH-1:0] a,
                                                        input logic [DATA_LENGTH-1:0] m);
        return (a >= m) ? (a - m) : a;
    endfunction

    state_t                 state;
    state_t                 state_n;
    logic [DATA_LENGTH-1:0] acc;
    logic [CNTW-1:0]        cnt;
    logic                   load;
    logic                   fold;
    logic                   done;

    logic [DATA_LENGTH-1:0] m_eff;
    logic [BLW-1:0]         bl_eff;
    logic [DATA_LENGTH-1:0] c_eff;

`ifdef SHIFTADD_KYBER_CONST_EN
    // Operand ports carrying the modulus are not needed with fixed constants.
    logic unused_cfg;
    assign unused_cfg = ^{m_i, m_bl_i};

    assign m_eff  = DEF_M;
    assign bl_eff = DEF_BL;
    assign c_eff  = tap_mask(DEF_BL, DEF_M);
`else
    logic [DATA_LENGTH-1:0] m_r;
    logic [BLW-1:0]         bl_r;
    logic [DATA_LENGTH-1:0] c_r;

    // Only the low bits of m_bl_i select a bit length.
    logic unused_bl_hi;
    assign unused_bl_hi = ^m_bl_i[DATA_LENGTH-1:BLW];

    // Capture the modulus configuration when a start is accepted.
    always_ff @(posedge CLK_pci_sys_clk_p or negedge rst_ni) begin
        if (!rst_ni) begin
            m_r  <= DEF_M;
            bl_r <= DEF_BL;
            c_r  <= tap_mask(DEF_BL, DEF_M);
        end else if (load) begin
            m_r  <= m_i;
            bl_r <= m_bl_i[BLW-1:0];
            c_r  <= tap_mask(m_bl_i[BLW-1:0], m_i);
        end
    end

    assign m_eff  = m_r;
    assign bl_eff = bl_r;
    assign c_eff  = c_r;
`endif

    // Split of the accumulator at the bit-length boundary.
    logic [DATA_LENGTH-1:0] lo;
    logic [DATA_LENGTH-1:0] hi;
    logic                   need_fold;

    assign lo        = acc & low_mask(bl_eff);
    assign hi        = acc >> bl_eff;
    assign need_fold = |hi;

    // Heap-ordered adder tree: node[0] is the root, leaves start at NP-1.
    logic [DATA_LENGTH-1:0] node [0:2*NP-2];
    logic [DATA_LENGTH-1:0] fold_sum;

    for (genvar i = 0; i < NP; i++) begin : g_leaf
        if (i < DATA_LENGTH) begin : g_tap
            assign node[NP-1+i] = c_eff[i] ? (hi << i) : '0;
        end else begin : g_pad
            assign node[NP-1+i] = '0;
        end
    end

    for (genvar k = 0; k < NP - 1; k++) begin : g_add
        assign node[k] = node[2*k+1] + node[2*k+2];
    end

    assign fold_sum = lo + node[0];

    // State register.
    always_ff @(posedge CLK_pci_sys_clk_p or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and datapath strobes; the fold counter forces an exit
    // when an illegal modulus keeps the loop from converging.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        fold    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    state_n = FOLD;
                end
            end
            FOLD: begin
                if (need_fold && (cnt != CNT_MAX)) begin
                    fold = 1'b1;
                end else begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Accumulator, fold counter, result and completion pulse.
    always_ff @(posedge CLK_pci_sys_clk_p or negedge rst_ni) begin
        if (!rst_ni) begin
            acc      <= '0;
            cnt      <= '0;
            result_o <= '0;
            valid_o  <= 1'b0;
        end else begin
            valid_o <= done;
            if (load) begin
                acc      <= x_i;
                cnt      <= '0;
                result_o <= '0;
            end else if (fold) begin
                acc <= fold_sum;
                cnt <= cnt + 1'b1;
            end
            if (done) begin
                result_o <= cond_sub(acc, m_eff);
            end
        end
    end

endmodule

// File: tb/tb_shiftadd_parallel_top.sv
// Testbench for shiftadd_parallel_top: directed vector table, multi-cycle
// corner sequences (held start, start during fold, reset mid-operation)
// and randomized operands checked against x % m. Expected fold count is
// derived by applying the folding rule with plain integer arithmetic.
// Build option: SHIFTADD_KYBER_CONST_EN restricts stimulus to m = 3329.

module tb_shiftadd_parallel_top;

    localparam int DL = 64;
    localparam logic [DL-1:0] KQ = 64'd3329;

    typedef struct {
        logic [DL-1:0] x;
        logic [DL-1:0] m;
        logic [DL-1:0] bl;
        logic [DL-1:0] res;
        int            lat;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DL-1:0] x;
    logic [DL-1:0] m;
    logic [DL-1:0] bl;
    logic [DL-1:0] result;
    logic          valid;

    int checks;
    int errors;

    shiftadd_parallel_top dut (
        .CLK_pci_sys_clk_p (clk),
        .rst_ni            (rst_n),
        .start_i           (start),
        .x_i               (x),
        .m_i               (m),
        .m_bl_i            (bl),
        .result_o          (result),
        .valid_o           (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DL-1:0] act, input logic [DL-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Modulus value actually driven on m_i (ignored in the constant build).
    function automatic logic [DL-1:0] mdrv(input logic [DL-1:0] mv);
`ifdef SHIFTADD_KYBER_CONST_EN
        return '0 & mv;
`else
        return mv;
`endif
    endfunction

    // Number of folds the reduction rule needs before x drops below 2^bl.
    function automatic int model_folds(input longint unsigned xv, input longint unsigned mv, input int blv);
        longint unsigned a, p, c;
        int n;
        a = xv;
        p = 64'd1 << blv;
        c = p - mv;
        n = 0;
        while (a >= p && n < 200) begin
            a = (a % p) + (a / p) * c;
            n++;
        end
        return n;
    endfunction

    // One operation: start, wait for valid, then check pulse width and hold.
    task automatic run_op(input logic [DL-1:0] xv, input logic [DL-1:0] mv, input logic [DL-1:0] blv,
                          input bit glitch, output logic [DL-1:0] res, output int lat);
        @(negedge clk);
        start = 1'b1; x = xv; m = mdrv(mv); bl = blv;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        chk("clr_result", result, '0);
        chk("clr_valid", {63'd0, valid}, '0);
        while (valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (glitch && lat == 2) begin
                start = 1'b1;
                x     = 64'h0D01;
            end else begin
                start = 1'b0;
            end
        end
        res = result;
        @(negedge clk);
        chk("pulse_width", {63'd0, valid}, '0);
        chk("hold", result, res);
    endtask

    initial begin
        vec_t          tbl[$];
        logic [DL-1:0] res;
        int            lat;
        int            cnt;
        logic [DL-1:0] xv;
        logic [DL-1:0] mv;
        logic [DL-1:0] blv;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        x      = '0;
        m      = '0;
        bl     = '0;

        tbl.push_back('{64'h0D01,  KQ, 64'd12, 64'h000, 2});
        tbl.push_back('{64'h0D00,  KQ, 64'd12, 64'hD00, 2});
        tbl.push_back('{64'h1000,  KQ, 64'd12, 64'h2FF, 3});
        tbl.push_back('{64'h10000, KQ, 64'd12, 64'h8ED, 5});
        tbl.push_back('{64'h0,     KQ, 64'd12, 64'h000, 2});
        tbl.push_back('{64'hFFF,   KQ, 64'd12, 64'd766, 2});
`ifndef SHIFTADD_KYBER_CONST_EN
        tbl.push_back('{64'h1FFF,  64'd7681, 64'd13, 64'd510, 2});
        tbl.push_back('{64'h2000,  64'd7681, 64'd13, 64'd511, 3});
        tbl.push_back('{64'h1E01,  64'd7681, 64'd13, 64'd0,   2});
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", result, '0);
        chk("rst_valid", {63'd0, valid}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_op(tbl[i].x, tbl[i].m, tbl[i].bl, 1'b0, res, lat);
            chk($sformatf("vec%0d_result", i), res, tbl[i].res);
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
        end

        // start held high: a new operation begins at every IDLE edge
        @(negedge clk);
        start = 1'b1; x = 64'h1000; m = mdrv(KQ); bl = 64'd12;
        cnt = 0;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
            if (valid === 1'b1) cnt++;
        end
        start = 1'b0;
        chk("restart_pulses", cnt, 3);
        chk("restart_result", result, 64'h2FF);
        @(negedge clk);

        // start pulsed during FOLD must be ignored
        run_op(64'h10000, KQ, 64'd12, 1'b1, res, lat);
        chk("glitch_result", res, 64'h8ED);
        chk("glitch_latency", lat, 5);

        // reset during the second fold cycle aborts without a valid pulse
        @(negedge clk);
        start = 1'b1; x = 64'hFFFF_FFFF; m = mdrv(KQ); bl = 64'd12;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_result", result, '0);
        chk("midrst_valid", {63'd0, valid}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (valid === 1'b1) cnt++;
        end
        chk("midrst_no_valid", cnt, 0);
        run_op(64'h1000, KQ, 64'd12, 1'b0, res, lat);
        chk("postrst_result", res, 64'h2FF);
        chk("postrst_latency", lat, 3);

        // randomized operands against x % m
        for (int i = 0; i < 3000; i++) begin
            mv  = KQ;
            blv = 64'd12;
`ifndef SHIFTADD_KYBER_CONST_EN
            if ((i % 4) >= 2) begin
                mv  = 64'd7681;
                blv = 64'd13;
            end
`endif
            if ((i % 2) == 0) xv = {32'd0, 32'($urandom)};
            else              xv = {32'($urandom), 32'($urandom)};
            run_op(xv, mv, blv, 1'b0, res, lat);
            chk($sformatf("rand%0d_result x=%0h", i, xv), res, xv % mv);
            chk($sformatf("rand%0d_latency x=%0h", i, xv), lat, model_folds(xv, mv, int'(blv)) + 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
